regfile_wr_arbiter: RTL

- Sequences and shares the single write port of the 32x32 register file (WriteReg / WriteData / Regwrt) among NREQ writeback requesters, e.g. ALU, load unit and multiplier.
- Round-robin arbitration with valid/ready handshakes, one registered output stage driving the register file write port.
- After reset, sweeps all 32 registers to zero before granting any requester.
- Sits between the writeback sources and the register file.

---
 rtl/regfile_wr_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin writeback arbiter with zero-fill sweep for the 32x32 register file
// Optional feature macro: REGFILE_DROP_CNT_EN (enables the saturating address-0 drop counter)
module regfile_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 clr_req,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // One extra bit so the counter can record that address 2^AW-1 has been loaded.
    logic [AW:0]     clr_idx;
    logic            sweep_done;
    logic [2:0]      rr_ptr;

    logic            any_valid;
    logic [2:0]      pick;
    logic            grant_go;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            sel_is_zero;

    assign sweep_done  = clr_idx[AW];
    assign sel_is_zero = (sel_addr == '0);

    // Round-robin search: first valid requester at or above rr_ptr, else wrap to the lowest valid one.
    always_comb begin
        any_valid = 1'b0;
        pick      = 3'd0;
        for (int c = 0; c < NREQ; c++) begin
            if (!any_valid && req_valid[c] && (3'(c) >= rr_ptr)) begin
                any_valid = 1'b1;
                pick      = 3'(c);
            end
        end
        for (int c = 0; c < NREQ; c++) begin
            if (!any_valid && req_valid[c]) begin
                any_valid = 1'b1;
                pick      = 3'(c);
            end
        end
    end

    // Select the winning requester's address and data from the packed buses.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int c = 0; c < NREQ; c++) begin
            if (pick == 3'(c)) begin
                sel_addr = req_addr[c*AW +: AW];
                sel_data = req_data[c*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant decision and status; a sweep request in ARB suppresses any grant that cycle.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        grant_go  = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (sweep_done) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                end else if (!hold && any_valid) begin
                    grant_go = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // One-hot ready for the selected requester.
    always_comb begin
        req_ready = '0;
        for (int c = 0; c < NREQ; c++) begin
            req_ready[c] = grant_go && (pick == 3'(c));
        end
    end

    // Registered write port: sweep writes in CLEAR, accepted requests in ARB; address-0 writes are swallowed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= 3'd0;
            rr_ptr   <= 3'd0;
            clr_idx  <= '0;
        end else if (state == ST_CLEAR) begin
            if (!sweep_done) begin
                wr_en   <= 1'b1;
                wr_addr <= clr_idx[AW-1:0];
                wr_data <= '0;
                clr_idx <= clr_idx + 1'b1;
            end else begin
                wr_en   <= 1'b0;
            end
        end else if (clr_req) begin
            wr_en   <= 1'b0;
            clr_idx <= '0;
        end else if (grant_go) begin
            grant_id <= pick;
            rr_ptr   <= (pick == 3'(NREQ-1)) ? 3'd0 : pick + 3'd1;
            wr_en    <= !sel_is_zero;
            if (!sel_is_zero) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end else begin
            wr_en <= 1'b0;
        end
    end

`ifdef REGFILE_DROP_CNT_EN
    logic [7:0] drop_q;

    // Saturating count of accepted writes aimed at the hard-wired zero register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (grant_go && sel_is_zero && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
